instr_encoder: RTL and testbench

- Streaming RV32I instruction encoder: the encode-side counterpart of the main decoder.
- Accepts decoded instruction fields over a valid/ready handshake and emits the packed 32-bit instruction word.
- Tags each word with a sequential instruction-memory byte address.
- Used by the boot/debug loader and test harness to inject programs into instruction memory.
- Every opcode legal in the decoder's table is encodable here.

---
 rtl/instr_encoder.sv | 188 ++++++++++++++++++
 tb/tb_instr_encoder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Streaming RV32I instruction encoder: packs decoded fields into 32-bit words tagged with byte addresses.
// Define INSTR_ENC_CHECK_EN to compile in immediate-range and opcode-legality checks on out_err.
module instr_encoder #(
    parameter int unsigned       ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              addr_clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fmt,
    input  logic [6:0]        in_opcode,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err
);

    localparam logic [2:0]  FMT_R = 3'd0;
    localparam logic [2:0]  FMT_I = 3'd1;
    localparam logic [2:0]  FMT_S = 3'd2;
    localparam logic [2:0]  FMT_B = 3'd3;
    localparam logic [2:0]  FMT_U = 3'd4;
    localparam logic [2:0]  FMT_J = 3'd5;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    typedef struct packed {
        logic [31:0]       instr;
        logic [ADDR_W-1:0] addr;
        logic              err;
    } word_t;

    localparam word_t RST_WORD = '{instr: 32'h0, addr: START_ADDR, err: 1'b0};

    state_t            state, state_nxt;
    word_t             out_q, skid_q, new_word;
    logic [ADDR_W-1:0] addr_cnt, addr_cur;
    logic              in_ready_q, out_valid_q;
    logic              in_hs, out_hs;
    logic              load_out, load_skid, skid_to_out;
    logic [31:0]       enc_instr;
    logic              enc_err;
    logic              chk_err;

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_instr = out_q.instr;
    assign out_addr  = out_q.addr;
    assign out_err   = out_q.err;

    assign in_hs  = in_valid & in_ready_q;
    assign out_hs = out_valid_q & out_ready;

    // Field packing; immediates are truncated to whatever bits the format carries.
    always_comb begin
        enc_instr = NOP;
        enc_err   = 1'b0;
        case (in_fmt)
            FMT_R: enc_instr = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            FMT_I: enc_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
            FMT_S: enc_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
            FMT_B: enc_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                                in_imm[4:1], in_imm[11], in_opcode};
            FMT_U: enc_instr = {in_imm[31:12], in_rd, in_opcode};
            FMT_J: enc_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                                in_rd, in_opcode};
            default: begin
                enc_instr = NOP;
                enc_err   = 1'b1;
            end
        endcase
        if (chk_err)
            enc_err = 1'b1;
    end

`ifdef INSTR_ENC_CHECK_EN
    logic signed [31:0] imm_s;
    assign imm_s = $signed(in_imm);

    always_comb begin
        chk_err = 1'b0;
        case (in_fmt)
            FMT_R: chk_err = (in_opcode != 7'b0110011);
            FMT_I: chk_err = (imm_s < -32'sd2048) || (imm_s > 32'sd2047) ||
                             !(in_opcode inside {7'b0000011, 7'b0010011, 7'b1100111});
            FMT_S: chk_err = (imm_s < -32'sd2048) || (imm_s > 32'sd2047) ||
                             (in_opcode != 7'b0100011);
            FMT_B: chk_err = (imm_s < -32'sd4096) || (imm_s > 32'sd4094) || in_imm[0] ||
                             (in_opcode != 7'b1100011);
            FMT_U: chk_err = (in_imm[11:0] != 12'h0) ||
                             !(in_opcode inside {7'b0110111, 7'b0010111});
            FMT_J: chk_err = (imm_s < -32'sd1048576) || (imm_s > 32'sd1048574) || in_imm[0] ||
                             (in_opcode != 7'b1101111);
            default: chk_err = 1'b0;
        endcase
    end
`else
    assign chk_err = 1'b0;
`endif

    // A clear in the same cycle as a handshake tags this word with START_ADDR.
    assign addr_cur = addr_clr ? START_ADDR : addr_cnt;
    assign new_word = '{instr: enc_instr, addr: addr_cur, err: enc_err};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= EMPTY;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        load_out    = 1'b0;
        load_skid   = 1'b0;
        skid_to_out = 1'b0;
        case (state)
            EMPTY: begin
                if (in_hs) begin
                    state_nxt = ONE;
                    load_out  = 1'b1;
                end
            end
            ONE: begin
                if (in_hs && out_hs) begin
                    load_out = 1'b1;
                end else if (in_hs) begin
                    state_nxt = TWO;
                    load_skid = 1'b1;
                end else if (out_hs) begin
                    state_nxt = EMPTY;
                end
            end
            TWO: begin
                if (out_hs) begin
                    state_nxt   = ONE;
                    skid_to_out = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // Handshake flags come from the next state so neither is combinational on out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            in_ready_q  <= (state_nxt != TWO);
            out_valid_q <= (state_nxt != EMPTY);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q  <= RST_WORD;
            skid_q <= RST_WORD;
        end else begin
            if (load_out)
                out_q <= new_word;
            else if (skid_to_out)
                out_q <= skid_q;
            if (load_skid)
                skid_q <= new_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            addr_cnt <= START_ADDR;
        else if (in_hs)
            addr_cnt <= addr_cur + ADDR_W'(4);
        else if (addr_clr)
            addr_cnt <= START_ADDR;
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: vector table streamed through, plus backpressure, reset and clear sequences.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        addr_clr = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_fmt = '0;
    logic [6:0]  in_opcode = '0;
    logic [2:0]  in_funct3 = '0;
    logic [6:0]  in_funct7 = '0;
    logic [4:0]  in_rd = '0;
    logic [4:0]  in_rs1 = '0;
    logic [4:0]  in_rs2 = '0;
    logic [31:0] in_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        out_err;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(32), .START_ADDR(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .addr_clr(addr_clr),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err)
    );

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] exp_instr;
        logic        err_nc;
        logic        err_c;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] addr;
        logic        err;
    } word_t;

    vec_t  vecs[17];
    word_t got_q[$];
    word_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    logic [31:0] exp_addr = 32'h0;

    // Record every accepted output word just before the edge that takes it.
    always begin
        @(negedge clk);
        #4;
        if (rst_n && out_valid && out_ready)
            got_q.push_back('{instr: out_instr, addr: out_addr, err: out_err});
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic send(input vec_t v, input logic clr);
        int n;
        @(negedge clk);
        in_fmt = v.fmt; in_opcode = v.op; in_funct3 = v.f3; in_funct7 = v.f7;
        in_rd = v.rd; in_rs1 = v.rs1; in_rs2 = v.rs2; in_imm = v.imm;
        addr_clr = clr;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stuck at 0 after %0d cycles", n);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        addr_clr = 1'b0;
    endtask

    task automatic send_exp(input vec_t v, input logic clr);
        word_t w;
        logic  e;
`ifdef INSTR_ENC_CHECK_EN
        e = v.err_c;
`else
        e = v.err_nc;
`endif
        if (clr)
            exp_addr = 32'h0;
        w = '{instr: v.exp_instr, addr: exp_addr, err: e};
        exp_addr = exp_addr + 32'd4;
        exp_q.push_back(w);
        send(v, clr);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (got_q.size() < exp_q.size() && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check({name, "_count"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            word_t g, x;
            g = got_q.pop_front();
            x = exp_q.pop_front();
            checks++;
            if (g.instr !== x.instr || g.addr !== x.addr || g.err !== x.err) begin
                errors++;
                $display("FAIL %s_word: got instr=0x%08h addr=0x%08h err=%0b expected instr=0x%08h addr=0x%08h err=%0b",
                         name, g.instr, g.addr, g.err, x.instr, x.addr, x.err);
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        vecs[0]  = '{3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5,        32'h00500093, 1'b0, 1'b0};
        vecs[1]  = '{3'd2, 7'h23, 3'd2, 7'h00, 5'd0, 5'd1, 5'd2, 32'd8,        32'h0020A423, 1'b0, 1'b0};
        vecs[2]  = '{3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, 32'hFE000EE3, 1'b0, 1'b0};
        vecs[3]  = '{3'd5, 7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd2048,     32'h001000EF, 1'b0, 1'b0};
        vecs[4]  = '{3'd4, 7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h12345000, 32'h123452B7, 1'b0, 1'b0};
        vecs[5]  = '{3'd0, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'h0,        32'h002081B3, 1'b0, 1'b0};
        vecs[6]  = '{3'd0, 7'h33, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 32'h0,        32'h402081B3, 1'b0, 1'b0};
        vecs[7]  = '{3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF, 32'hFFF00093, 1'b0, 1'b0};
        vecs[8]  = '{3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'd4094,     32'h7E000FE3, 1'b0, 1'b0};
        vecs[9]  = '{3'd5, 7'h6F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFE, 32'hFFFFF06F, 1'b0, 1'b0};
        vecs[10] = '{3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd2048,     32'h80000093, 1'b0, 1'b1};
        vecs[11] = '{3'd7, 7'h33, 3'd1, 7'h7F, 5'd9, 5'd9, 5'd9, 32'h0,        32'h00000013, 1'b1, 1'b1};
        vecs[12] = '{3'd4, 7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h12345678, 32'h123452B7, 1'b0, 1'b1};
        vecs[13] = '{3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'd3,        32'h00000163, 1'b0, 1'b1};
        vecs[14] = '{3'd1, 7'h33, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd1,        32'h001000B3, 1'b0, 1'b1};
        vecs[15] = '{3'd2, 7'h23, 3'd2, 7'h00, 5'd0, 5'd1, 5'd2, 32'hFFFFF800, 32'h8020A023, 1'b0, 1'b0};
        vecs[16] = '{3'd6, 7'h13, 3'd0, 7'h00, 5'd1, 5'd1, 5'd1, 32'd7,        32'h00000013, 1'b1, 1'b1};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_instr", out_instr, 0);
        check("rst_out_addr", out_addr, 0);
        check("rst_out_err", out_err, 0);
        rst_n = 1'b1;

        // First-word latency: valid one cycle after the input handshake
        send_exp(vecs[0], 1'b0);
        check("latency_out_valid", out_valid, 1);
        check("latency_out_instr", out_instr, 32'h00500093);
        drain("first");

        // Whole table streamed back-to-back with the sink always ready
        for (int i = 0; i < 17; i++)
            send_exp(vecs[i], 1'b0);
        drain("table");

        // Backpressure: third input stalls until the sink frees a slot
        exp_addr = 32'h0;
        send_exp(vecs[0], 1'b1);
        drain("clr_pre");
        out_ready = 1'b0;
        send_exp(vecs[5], 1'b0);
        send_exp(vecs[1], 1'b0);
        fork
            send_exp(vecs[4], 1'b0);
            begin
                @(negedge clk);
                check("bp_in_ready_low1", in_ready, 0);
                @(negedge clk);
                check("bp_in_ready_low2", in_ready, 0);
                check("bp_hold_instr", out_instr, 32'h002081B3);
                check("bp_hold_addr", out_addr, 32'h4);
                out_ready = 1'b1;
            end
        join
        drain("backpressure");

        // Reset while both slots are full drops everything
        out_ready = 1'b0;
        send(vecs[2], 1'b0);
        send(vecs[3], 1'b0);
        @(negedge clk);
        check("two_in_ready", in_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_addr", out_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        exp_addr = 32'h0;
        send_exp(vecs[6], 1'b0);
        send_exp(vecs[7], 1'b0);
        drain("after_reset");

        // Clear coinciding with a handshake, then a standalone clear pulse
        send_exp(vecs[8], 1'b1);
        send_exp(vecs[9], 1'b0);
        @(negedge clk);
        addr_clr = 1'b1;
        @(negedge clk);
        addr_clr = 1'b0;
        exp_addr = 32'h0;
        send_exp(vecs[15], 1'b0);
        drain("addr_clr");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
